// File: rtl/adc_frame_packer.sv
// adc_frame_packer
//   Block-averages 2^LOG2_AVG ADC conversions, tags each average with a
//   rolling 4-bit sequence number, buffers the 16-bit frame words in a small
//   FIFO and feeds them to a 2-byte UART through a tx_start/tx_busy handshake.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   adc_eoc         single-cycle end-of-conversion strobe
//   adc_data[11:0]  conversion result, valid with adc_eoc
//   tx_busy         transmitter busy flag
//   tx_start        one-cycle pulse launching a frame
//   tx_data[15:0]   frame word {avg[7:0], seq[3:0], avg[11:8]}, low byte first
//   fifo_count      number of buffered words
//   overflow        sticky: at least one average was dropped
module adc_frame_packer #(
  parameter int LOG2_AVG = 2,
  parameter int FIFO_AW  = 3,
  parameter int BUSY_TMO = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adc_eoc,
  input  logic [11:0]      adc_data,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [15:0]      tx_data,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overflow
);

  localparam int ACC_W = 12 + LOG2_AVG;
  // Pass-through still needs a 1-bit counter; it simply never leaves 0.
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int MEM_N = 1 << FIFO_AW;
  localparam int TMO_W = (BUSY_TMO > 1) ? $clog2(BUSY_TMO + 1) : 1;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(MEM_N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [TMO_W-1:0] TMO_END  = TMO_W'(BUSY_TMO - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  logic [ACC_W-1:0]   acc, sum;
  logic [CNT_W-1:0]   cnt;
  logic [11:0]        avg;
  logic [3:0]         seq;
  logic [15:0]        word;
  logic               last, push, pop, full, wr_en;
  logic [15:0]        mem [MEM_N];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  state_t             state;
  logic [TMO_W-1:0]   tmo;

  // ---------------- averager ----------------
  assign sum  = acc + ACC_W'(adc_data);
  assign avg  = 12'(sum >> LOG2_AVG);
  assign last = (cnt == LAST_CNT);
  assign push = adc_eoc & last;
  assign word = {avg[7:0], seq, avg[11:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      seq <= '0;
    end else if (adc_eoc) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
        // seq advances even when the word is dropped so the host sees a gap
        seq <= seq + 4'd1;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // ---------------- FIFO ----------------
  assign full  = (fifo_count == FULL_CNT);
  assign pop   = (state == IDLE) && (fifo_count != '0) && !tx_busy;
  // A pop on the same edge frees the slot, so a full FIFO still accepts it.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && !wr_en) overflow <= 1'b1;
    end
  end

  // ---------------- transmit FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      tmo      <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          tx_data  <= mem[rd_ptr];
          tx_start <= 1'b1;
          tmo      <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy)             state <= WAIT_DONE;
          // A transmitter that never answers must not stall the queue;
          // the frame is treated as sent.
          else if (tmo == TMO_END) state <= IDLE;
          else                     tmo   <= tmo + 1'b1;
        end
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Self-checking bench for adc_frame_packer: one averaging instance
// (LOG2_AVG=2) and one pass-through instance (LOG2_AVG=0), each with its own
// behavioural UART model and frame monitor.
`timescale 1ns/1ps
module tb_adc_frame_packer;
  localparam int LA = 2, NAVG = 1 << LA, FAW = 3, DEPTH = 1 << FAW, TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic eoc_a = 1'b0, eoc_p = 1'b0;
  logic [11:0] data_a = '0, data_p = '0;
  logic busy_a = 1'b0, busy_p = 1'b0;
  logic start_a, start_p, ovf_a, ovf_p;
  logic [15:0] txd_a, txd_p;
  logic [FAW:0] cnt_a, cnt_p;

  always #5 clk = ~clk;

  adc_frame_packer #(.LOG2_AVG(LA), .FIFO_AW(FAW), .BUSY_TMO(TMO)) u_dut (
    .clk(clk), .rst(rst), .adc_eoc(eoc_a), .adc_data(data_a), .tx_busy(busy_a),
    .tx_start(start_a), .tx_data(txd_a), .fifo_count(cnt_a), .overflow(ovf_a));

  adc_frame_packer #(.LOG2_AVG(0), .FIFO_AW(FAW), .BUSY_TMO(TMO)) u_pass (
    .clk(clk), .rst(rst), .adc_eoc(eoc_p), .adc_data(data_p), .tx_busy(busy_p),
    .tx_start(start_p), .tx_data(txd_p), .fifo_count(cnt_p), .overflow(ovf_p));

  int n_checks = 0, n_fail = 0;

  // posedge counter; eoc_cyc_* = index of the edge that sampled the last eoc
  int pcyc = 0, eoc_cyc_a = 0, eoc_cyc_p = 0;
  always @(posedge clk) begin
    pcyc <= pcyc + 1;
    if (eoc_a) eoc_cyc_a <= pcyc;
    if (eoc_p) eoc_cyc_p <= pcyc;
  end

  // UART models and frame monitors (negedge, away from the DUT edge)
  int  busy_len = 20;
  bit  busy_force = 0, busy_never = 0;
  int  bcnt_a = 0, bcnt_p = 0, fall_a = 0, fall_p = 0;
  logic [15:0] frm_a[$], frm_p[$];
  int  fcyc_a[$], fcyc_p[$];

  always @(negedge clk) begin
    if (start_a) begin frm_a.push_back(txd_a); fcyc_a.push_back(pcyc); end
    if (start_p) begin frm_p.push_back(txd_p); fcyc_p.push_back(pcyc); end
    if (rst) begin busy_a = 0; bcnt_a = 0; end
    else if (busy_force) busy_a = 1;
    else if (busy_never) busy_a = 0;
    else if (start_a) begin busy_a = 1; bcnt_a = busy_len; end
    else if (bcnt_a > 0) begin
      bcnt_a--;
      if (bcnt_a == 0) begin busy_a = 0; fall_a = pcyc; end
    end else busy_a = 0;
    if (rst) begin busy_p = 0; bcnt_p = 0; end
    else if (start_p) begin busy_p = 1; bcnt_p = busy_len; end
    else if (bcnt_p > 0) begin
      bcnt_p--;
      if (bcnt_p == 0) begin busy_p = 0; fall_p = pcyc; end
    end else busy_p = 0;
  end

  // Reference model for the averaging instance: frame words in order.
  logic [15:0] exp_a[$];
  logic [3:0]  mseq_a = 0;
  bit          movf_a = 0;

  task automatic model_avg(input int s);
    logic [11:0] avg;
    logic [15:0] w;
    avg = 12'(s / NAVG);
    w = {avg[7:0], mseq_a, avg[11:8]};
    mseq_a = mseq_a + 4'd1;
    // words still inside the FIFO = produced-and-kept minus already sent
    if (exp_a.size() - frm_a.size() < DEPTH) exp_a.push_back(w);
    else movf_a = 1;
  endtask

  task automatic drive_a(input logic [11:0] v);
    @(negedge clk); eoc_a = 1; data_a = v;
    @(negedge clk); eoc_a = 0;
  endtask

  task automatic drive_p(input logic [11:0] v);
    @(negedge clk); eoc_p = 1; data_p = v;
    @(negedge clk); eoc_p = 0;
  endtask

  task automatic feed_avg(input int gmin, input int gmax);
    int s = 0;
    logic [11:0] v;
    for (int i = 0; i < NAVG; i++) begin
      v = 12'($urandom_range(0, 4095));
      s += v;
      drive_a(v);
      repeat ($urandom_range(gmin, gmax)) @(negedge clk);
    end
    model_avg(s);
  endtask

  task automatic wait_frames(input bit pass, input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((pass ? frm_p.size() : frm_a.size()) >= n) begin ok = 1; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; eoc_a = 0; eoc_p = 0;
    repeat (2) @(negedge clk);
    exp_a.delete(); frm_a.delete(); fcyc_a.delete();
    frm_p.delete(); fcyc_p.delete();
    mseq_a = 0; movf_a = 0;
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++; if (start_a !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start got=%b exp=0", start_a); end
    n_checks++; if (txd_a !== 16'h0000) begin n_fail++; $display("FAIL reset_tx_data got=%h exp=0000", txd_a); end
    n_checks++; if (cnt_a !== '0) begin n_fail++; $display("FAIL reset_fifo_count got=%0d exp=0", cnt_a); end
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", ovf_a); end
    do_reset();
  endtask

  task automatic test_directed_avg();
    bit ok;
    busy_len = 20;
    drive_a(12'd100); drive_a(12'd101); drive_a(12'd102); drive_a(12'd105);
    wait_frames(0, 1, 50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL avg_frame_timeout got=0 frames exp=1"); end
    n_checks++; if (frm_a[0] !== 16'h6600) begin n_fail++; $display("FAIL avg_word got=%h exp=6600", frm_a[0]); end
    // last eoc edge k, pop edge k+1, monitor sees pcyc=k+2
    n_checks++; if (fcyc_a[0] - eoc_cyc_a != 2) begin n_fail++; $display("FAIL avg_latency got=%0d exp=2", fcyc_a[0] - eoc_cyc_a); end
    repeat (30) @(negedge clk);
    n_checks++; if (frm_a.size() != 1) begin n_fail++; $display("FAIL avg_pulse_count got=%0d exp=1", frm_a.size()); end
  endtask

  task automatic test_passthrough();
    bit ok;
    busy_len = 20;
    drive_p(12'hABC); drive_p(12'h123);
    wait_frames(1, 2, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL pass_timeout got=%0d frames exp=2", frm_p.size()); end
    n_checks++; if (frm_p[0] !== 16'hBC0A) begin n_fail++; $display("FAIL pass_word0 got=%h exp=bc0a", frm_p[0]); end
    n_checks++; if (frm_p[1] !== 16'h2311) begin n_fail++; $display("FAIL pass_word1 got=%h exp=2311", frm_p[1]); end
    // busy drops mid-cycle; next edge -> IDLE, following edge pulses
    n_checks++; if (fcyc_p[1] - fall_p != 2) begin n_fail++; $display("FAIL pass_b2b_gap got=%0d exp=2", fcyc_p[1] - fall_p); end
    repeat (25) @(negedge clk);
    n_checks++; if (frm_p.size() != 2) begin n_fail++; $display("FAIL pass_pulse_count got=%0d exp=2", frm_p.size()); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    busy_force = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) feed_avg(0, 2);
    repeat (2) @(negedge clk);
    n_checks++; if (cnt_a !== 4'(DEPTH)) begin n_fail++; $display("FAIL ovf_count got=%0d exp=%0d", cnt_a, DEPTH); end
    n_checks++; if (ovf_a !== 1'b1 || movf_a != 1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=%b", ovf_a, movf_a); end
    busy_len = 3; busy_force = 0;
    wait_frames(0, 8, 300, ok);
    feed_avg(0, 1);
    wait_frames(0, 9, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_drain got=%0d frames exp=9", frm_a.size()); end
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (frm_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL ovf_frame%0d got=%h exp=%h", i, frm_a[i], exp_a[i]); end
    end
    n_checks++; if (frm_a[8][7:4] !== 4'd10) begin n_fail++; $display("FAIL ovf_seq_gap got=%0d exp=10", frm_a[8][7:4]); end
    n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", ovf_a); end
  endtask

  task automatic test_seq_wrap();
    bit ok;
    do_reset();
    busy_len = 3;
    for (int i = 0; i < 20; i++) feed_avg(1, 4);
    wait_frames(0, 20, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout got=%0d frames exp=20", frm_a.size()); end
    for (int i = 0; i < 20; i++) begin
      n_checks++; if (frm_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_frame%0d got=%h exp=%h", i, frm_a[i], exp_a[i]); end
    end
    n_checks++; if (frm_a[15][7:4] !== 4'd15 || frm_a[16][7:4] !== 4'd0 || frm_a[19][7:4] !== 4'd3) begin
      n_fail++; $display("FAIL wrap_seq got=%0d,%0d,%0d exp=15,0,3", frm_a[15][7:4], frm_a[16][7:4], frm_a[19][7:4]);
    end
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL wrap_overflow got=%b exp=0", ovf_a); end
  endtask

  task automatic test_busy_timeout();
    bit ok;
    do_reset();
    busy_never = 1;
    feed_avg(0, 0); feed_avg(0, 0);
    wait_frames(0, 2, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_hang got=%0d frames exp=2", frm_a.size()); end
    n_checks++; if (fcyc_a[1] - fcyc_a[0] != TMO + 1) begin n_fail++; $display("FAIL tmo_gap got=%0d exp=%0d", fcyc_a[1] - fcyc_a[0], TMO + 1); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (frm_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL tmo_frame%0d got=%h exp=%h", i, frm_a[i], exp_a[i]); end
    end
    busy_never = 0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    busy_len = 40;
    repeat (4) drive_a(12'd1000);
    wait_frames(0, 1, 50, ok);
    repeat (3) @(negedge clk);
    repeat (4) drive_a(12'd1000);
    drive_a(12'd500); drive_a(12'd500);
    n_checks++; if (cnt_a !== 4'd1) begin n_fail++; $display("FAIL mid_pre_count got=%0d exp=1", cnt_a); end
    @(negedge clk); rst = 1; #1;
    n_checks++; if (start_a !== 1'b0 || txd_a !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_tx got=%b/%h exp=0/0000", start_a, txd_a); end
    n_checks++; if (cnt_a !== '0 || ovf_a !== 1'b0) begin n_fail++; $display("FAIL mid_reset_fifo got=%0d/%b exp=0/0", cnt_a, ovf_a); end
    @(negedge clk); rst = 0;
    frm_a.delete(); fcyc_a.delete(); exp_a.delete(); mseq_a = 0;
    repeat (4) drive_a(12'd4000);
    wait_frames(0, 1, 60, ok);
    n_checks++; if (!ok || frm_a[0] !== 16'hA00F) begin n_fail++; $display("FAIL mid_after_word got=%h exp=a00f", frm_a[0]); end
    repeat (5) @(negedge clk);
    n_checks++; if (frm_a.size() != 1) begin n_fail++; $display("FAIL mid_after_count got=%0d exp=1", frm_a.size()); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed_avg();
    test_passthrough();
    test_overflow();
    test_seq_wrap();
    test_busy_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_frame_packer.md
# adc_frame_packer

Sits between the XADC sampling stage and the 2-byte UART transmitter in the on-die temperature readout chain. Block-averages 2^LOG2_AVG consecutive ADC conversions. Stamps each average with a rolling 4-bit sequence number and buffers it in a small FIFO. Drives the transmitter's tx_start/tx_busy handshake so that ADC bursts never collide with a frame already on the serial line.

## Interface

Parameters:
- LOG2_AVG, 2: log2 of the number of conversions averaged per output word; the legal range is 0..6, and 0 means pass-through.
- FIFO_AW, 3: FIFO address width; depth is 2^FIFO_AW entries, each 16 bits wide.
- BUSY_TMO, 15: maximum number of cycles to wait for tx_busy to rise after a tx_start pulse.

Ports:
- clk  in  1  system clock (PLL output).
- rst  in  1  asynchronous, active-high reset.
- adc_eoc  in  1  single-cycle end-of-conversion strobe.
- adc_data  in  12  conversion result; valid in the cycle adc_eoc is high.
- tx_busy  in  1  transmitter busy flag.
- tx_start  out  1  single-cycle pulse that starts a 2-byte frame.
- tx_data  out  16  frame word = {avg[7:0], seq[3:0], avg[11:8]}; the low byte is sent first.
- fifo_count  out  FIFO_AW+1  number of words currently buffered.
- overflow  out  1  sticky flag: at least one average has been dropped.

## Operation

Averager:
- Accumulator is 12+LOG2_AVG bits wide; sample counter is LOG2_AVG bits wide.
- Each adc_eoc adds adc_data to the accumulator and increments the sample counter.
- On the 2^LOG2_AVG-th adc_eoc, the result is computed as avg = (acc + adc_data) >> LOG2_AVG.
  - Rounding is truncation.
  - The accumulator and sample counter clear on that same edge.
- With LOG2_AVG=0, every adc_eoc produces an average equal to adc_data.
- seq is a 4-bit counter that increments once per average produced, whether or not the word is stored, and wraps from 15 to 0.
  - The word carries the seq value before the increment. The first word after reset carries seq=0.

FIFO:
- On each produced average, the word {avg[7:0], seq, avg[11:8]} is written in the same edge.
- If the FIFO is full and no pop occurs on that edge, the word is dropped and overflow is set. The seq counter still advances, so the PC sees a gap.
- If push and pop happen on the same edge while full, the push is accepted and fifo_count stays unchanged.
- overflow clears only on rst.

Transmit FSM (states IDLE, WAIT_BUSY, WAIT_DONE):
- IDLE: when fifo_count≠0 and tx_busy=0:
  - pop the head entry into the tx_data register;
  - pulse tx_start for 1 cycle;
  - go to WAIT_BUSY.
- WAIT_BUSY:
  - if tx_busy=1, go to WAIT_DONE;
  - if tx_busy is still 0 after BUSY_TMO cycles, return to IDLE. The frame counts as sent and is not re-sent.
- WAIT_DONE: when tx_busy=0, go to IDLE.
- tx_data is held stable from the tx_start edge until the next pop.

Reset (asynchronous, active-high rst):
- Outputs: tx_start=0, tx_data=16'h0000, fifo_count=0, overflow=0.
- Internals: FSM=IDLE, accumulator=0, sample counter=0, seq=0, FIFO pointers=0.
- Reset asserted mid-frame or mid-average discards all partial state immediately. No tx_start is issued during reset or in the first cycle after release.

## Timing

- Final adc_eoc sampled at edge k: fifo_count increments after edge k. If the FSM is in IDLE with tx_busy=0, tx_start is high in the cycle after edge k+1, and the new tx_data is valid in that same cycle.
- Pop and the fifo_count decrement occur on the edge that raises tx_start.
- Back-to-back frames: the next tx_start comes no earlier than 1 cycle after tx_busy falls. The cycle in WAIT_DONE that sees tx_busy=0 returns to IDLE, and the next edge issues the pulse.
- adc_eoc is accepted every cycle, including during transmission and while the FIFO is full.
- tx_busy already high while in IDLE: no pop and no pulse until it falls.

## Test plan

- LOG2_AVG=2: feed samples 100, 101, 102, 105 → the frame carries avg=102 (408>>2), seq=0, giving tx_data=16'h6600; one tx_start pulse, 2 edges after the 4th eoc.
- LOG2_AVG=0: feed 12'hABC, then 12'h123 with tx_busy modelled at 20 cycles → tx_data=16'hBC0A, then 16'h2311; exactly one tx_start per frame; the second pulse comes 1 cycle after busy falls.
- FIFO_AW=3 with tx_busy held high: produce 10 averages → fifo_count saturates at 8 and overflow=1. After releasing tx_busy, 8 frames come out with seq 0..7; the next produced word carries seq=10.
- 20 consecutive averages → seq wraps 15→0→3 in frame order.
- tx_busy never rises → tx_start pulses, the FSM returns to IDLE after 15 cycles, and the next entry is issued; no hang.
- Assert rst for 1 cycle mid-WAIT_DONE with 2 samples accumulated → all outputs are at reset values immediately. The next 4 samples 4000 ×4 produce avg=4000, seq=0, giving tx_data=16'hA00F.
